// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared definitions for the seven-segment display controller:
//                active-high segment patterns for hex digits 0..F plus an
//                all-off pattern, the handshake FSM state type and the
//                nibble-to-segment decoder.
//                Segment bit order is {G,F,E,D,C,B,A}; A is bit 0.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] c_SEG_0     = 7'h3F;
    localparam logic [6:0] c_SEG_1     = 7'h06;
    localparam logic [6:0] c_SEG_2     = 7'h5B;
    localparam logic [6:0] c_SEG_3     = 7'h4F;
    localparam logic [6:0] c_SEG_4     = 7'h66;
    localparam logic [6:0] c_SEG_5     = 7'h6D;
    localparam logic [6:0] c_SEG_6     = 7'h7D;
    localparam logic [6:0] c_SEG_7     = 7'h07;
    localparam logic [6:0] c_SEG_8     = 7'h7F;
    localparam logic [6:0] c_SEG_9     = 7'h6F;
    localparam logic [6:0] c_SEG_A     = 7'h77;
    localparam logic [6:0] c_SEG_B     = 7'h7C;
    localparam logic [6:0] c_SEG_C     = 7'h39;
    localparam logic [6:0] c_SEG_D     = 7'h5E;
    localparam logic [6:0] c_SEG_E     = 7'h79;
    localparam logic [6:0] c_SEG_F     = 7'h71;
    localparam logic [6:0] c_SEG_BLANK = 7'h00;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } seg7_state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] w_seg;
        case (nibble)
            4'h0:    w_seg = c_SEG_0;
            4'h1:    w_seg = c_SEG_1;
            4'h2:    w_seg = c_SEG_2;
            4'h3:    w_seg = c_SEG_3;
            4'h4:    w_seg = c_SEG_4;
            4'h5:    w_seg = c_SEG_5;
            4'h6:    w_seg = c_SEG_6;
            4'h7:    w_seg = c_SEG_7;
            4'h8:    w_seg = c_SEG_8;
            4'h9:    w_seg = c_SEG_9;
            4'hA:    w_seg = c_SEG_A;
            4'hB:    w_seg = c_SEG_B;
            4'hC:    w_seg = c_SEG_C;
            4'hD:    w_seg = c_SEG_D;
            4'hE:    w_seg = c_SEG_E;
            default: w_seg = c_SEG_F;
        endcase
        return w_seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_scan_timer.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_timer
//  Description : Scan timebase. A tick counter runs 0..SCAN_DIV-1 and wraps;
//                tick is high while it sits at SCAN_DIV-1. The digit index
//                advances on every tick and wraps after NUM_DIGITS-1; a tick
//                at the last index marks the end of a scan frame.
//  Ports       : clk       system clock
//                rst       synchronous active-high reset
//                tick      counter at its last value this cycle
//                frame_end tick on the last digit index
//                idx       digit currently being scanned
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_timer #(
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV   = 4096,
    parameter int IDX_W      = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic             frame_end,
    output logic [IDX_W-1:0] idx
);

    localparam int               CNT_W      = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;

    assign tick      = (r_cnt == c_CNT_LAST);
    assign frame_end = tick && (r_idx == c_IDX_LAST);
    assign idx       = r_idx;

    always_comb begin
        w_cnt_nxt = tick ? '0 : r_cnt + CNT_W'(1);
        w_idx_nxt = r_idx;
        // Explicit wrap keeps non-power-of-two digit counts in range.
        if (frame_end) begin
            w_idx_nxt = '0;
        end else if (tick) begin
            w_idx_nxt = r_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_idx <= w_idx_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_display_ctrl
//  Description : Multi-digit hex seven-segment controller. Accepts a value
//                over valid/ready into a shadow register and commits it to
//                the display register only at a scan-frame end, so digits
//                never tear. Drives a static per-digit segment bus and a
//                time-multiplexed scan bus; all outputs are registered.
//                Optional build macro SEG7_BLANK_EN enables leading-zero
//                blanking (digit 0 is never blanked).
//  Ports       : i_Clk        system clock
//                i_Reset      synchronous active-high reset
//                i_Value      value to display, digit 0 in [3:0]
//                i_Valid      i_Value valid this cycle
//                o_Ready      controller can accept a value
//                o_Segments   static segments, digit k in [7k+6:7k]
//                o_Scan_Seg   segments of the scanned digit
//                o_Digit_Sel  one-hot scanned-digit enable
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int SCAN_DIV   = 4096,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    i_Clk,
    input  logic                    i_Reset,
    input  logic [4*NUM_DIGITS-1:0] i_Value,
    input  logic                    i_Valid,
    output logic                    o_Ready,
    output logic [7*NUM_DIGITS-1:0] o_Segments,
    output logic [6:0]              o_Scan_Seg,
    output logic [NUM_DIGITS-1:0]   o_Digit_Sel
);

    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int SEG_W = 7 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SEG_W-1:0]      c_POL_SEGS = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            c_POL_SCAN = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [NUM_DIGITS-1:0] c_POL_SEL  = (ACTIVE_LOW != 0) ? '1 : '0;

    // Active-high segment image of a whole value, blanking applied.
    function automatic logic [SEG_W-1:0] build_segs(input logic [VAL_W-1:0] val);
        logic [SEG_W-1:0] w_img;
        logic             w_lead;
        w_img  = '0;
        w_lead = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef SEG7_BLANK_EN
            if (w_lead && (val[4*k +: 4] == 4'h0) && (k != 0)) begin
                w_img[7*k +: 7] = c_SEG_BLANK;
            end else begin
                w_lead          = 1'b0;
                w_img[7*k +: 7] = hex_to_seg(val[4*k +: 4]);
            end
`else
            w_lead          = 1'b0;
            w_img[7*k +: 7] = hex_to_seg(val[4*k +: 4]);
`endif
        end
        return w_img;
    endfunction

    logic             w_tick;
    logic             w_frame_end;
    logic [IDX_W-1:0] w_idx;

    seg7_scan_timer #(
        .NUM_DIGITS (NUM_DIGITS),
        .SCAN_DIV   (SCAN_DIV),
        .IDX_W      (IDX_W)
    ) u_scan_timer (
        .clk        (i_Clk),
        .rst        (i_Reset),
        .tick       (w_tick),
        .frame_end  (w_frame_end),
        .idx        (w_idx)
    );

    seg7_state_e           r_state;
    seg7_state_e           w_state_nxt;
    logic [VAL_W-1:0]      r_shadow;
    logic [VAL_W-1:0]      w_shadow_nxt;
    logic [VAL_W-1:0]      r_display;
    logic [VAL_W-1:0]      w_display_nxt;
    logic                  r_ready;
    logic [SEG_W-1:0]      r_segments;
    logic [6:0]            r_scan_seg;
    logic [NUM_DIGITS-1:0] r_digit_sel;

    logic                  w_xfer;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [SEG_W-1:0]      w_img_nxt;
    logic [SEG_W-1:0]      w_img_rst;
    logic [6:0]            w_scan_nxt;
    logic [NUM_DIGITS-1:0] w_sel_nxt;

    assign w_xfer    = i_Valid && r_ready;
    assign w_img_rst = build_segs('0);

    always_comb begin
        w_state_nxt   = r_state;
        w_shadow_nxt  = r_shadow;
        w_display_nxt = r_display;
        case (r_state)
            ST_IDLE: begin
                // Only capture here, never commit: a transfer on a frame-end
                // cycle therefore waits for the following frame end.
                if (w_xfer) begin
                    w_shadow_nxt = i_Value;
                    w_state_nxt  = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_frame_end) begin
                    w_display_nxt = r_shadow;
                    w_state_nxt   = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from next-cycle display and index so a commit
    // or a digit step is visible on the very first cycle after its edge.
    always_comb begin
        w_idx_nxt = w_idx;
        if (w_frame_end) begin
            w_idx_nxt = '0;
        end else if (w_tick) begin
            w_idx_nxt = w_idx + IDX_W'(1);
        end
        w_img_nxt  = build_segs(w_display_nxt);
        w_scan_nxt = '0;
        w_sel_nxt  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_nxt == IDX_W'(k)) begin
                w_scan_nxt   = w_img_nxt[7*k +: 7];
                w_sel_nxt[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state     <= ST_IDLE;
            r_shadow    <= '0;
            r_display   <= '0;
            r_ready     <= 1'b0;
            r_segments  <= w_img_rst ^ c_POL_SEGS;
            r_scan_seg  <= w_img_rst[6:0] ^ c_POL_SCAN;
            r_digit_sel <= NUM_DIGITS'(1) ^ c_POL_SEL;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_display   <= w_display_nxt;
            r_ready     <= (w_state_nxt == ST_IDLE);
            r_segments  <= w_img_nxt ^ c_POL_SEGS;
            r_scan_seg  <= w_scan_nxt ^ c_POL_SCAN;
            r_digit_sel <= w_sel_nxt ^ c_POL_SEL;
        end
    end

    assign o_Ready     = r_ready;
    assign o_Segments  = r_segments;
    assign o_Scan_Seg  = r_scan_seg;
    assign o_Digit_Sel = r_digit_sel;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_display_ctrl
//  Description : Directed self-checking bench for seg7_display_ctrl with
//                NUM_DIGITS=2, SCAN_DIV=4, ACTIVE_LOW=1. Expected values are
//                hand-computed inverted segment patterns.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_display_ctrl;

    localparam int N   = 2;
    localparam int DIV = 4;

`ifdef SEG7_BLANK_EN
    localparam logic [13:0] c_EXP_RST = {7'h7F, 7'h40};
    localparam logic [13:0] c_EXP_07  = {7'h7F, 7'h78};
    localparam logic [13:0] c_EXP_00  = {7'h7F, 7'h40};
`else
    localparam logic [13:0] c_EXP_RST = {7'h40, 7'h40};
    localparam logic [13:0] c_EXP_07  = {7'h40, 7'h78};
    localparam logic [13:0] c_EXP_00  = {7'h40, 7'h40};
`endif
    localparam logic [13:0] c_EXP_A5 = {7'h08, 7'h12};
    localparam logic [13:0] c_EXP_3C = {7'h30, 7'h46};

    logic        clk;
    logic        rst;
    logic [7:0]  value;
    logic        valid;
    logic        ready;
    logic [13:0] segs;
    logic [6:0]  scan_seg;
    logic [1:0]  dsel;

    int n_vec;
    int n_bad;

    seg7_display_ctrl #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (DIV),
        .ACTIVE_LOW (1)
    ) dut (
        .i_Clk       (clk),
        .i_Reset     (rst),
        .i_Value     (value),
        .i_Valid     (valid),
        .o_Ready     (ready),
        .o_Segments  (segs),
        .o_Scan_Seg  (scan_seg),
        .o_Digit_Sel (dsel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle write, then wait for o_Ready to return (the commit cycle).
    task automatic write_commit(input logic [7:0] v, output int lat);
        value = v;
        valid = 1'b1;
        step();
        valid = 1'b0;
        chk("rdy_fall", 32'(ready), 32'd0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (ready) break;
        end
        chk("rdy_return", 32'(ready), 32'd1);
    endtask

    initial begin
        int lat;
        int hits;
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        value = 8'h00;
        valid = 1'b0;

        // Reset state
        repeat (3) step();
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_segs", 32'(segs), 32'(c_EXP_RST));
        chk("rst_sel", 32'(dsel), 32'h2);
        chk("rst_scan", 32'(scan_seg), 32'h40);
        rst = 1'b0;
        step();
        chk("rel_ready", 32'(ready), 32'd1);
        chk("rel_segs", 32'(segs), 32'(c_EXP_RST));

        // Single write A5
        write_commit(8'hA5, lat);
        chk("a5_lat_le9", 32'(lat <= 9), 32'd1);
        chk("a5_segs", 32'(segs), 32'(c_EXP_A5));

        // Scan: commit cycle starts digit 0; each digit held DIV cycles
        for (int i = 0; i < 2 * N * DIV; i++) begin
            chk("scan_sel", 32'(dsel), ((i / DIV) % 2 == 0) ? 32'h2 : 32'h1);
            chk("scan_seg", 32'(scan_seg), ((i / DIV) % 2 == 0) ? 32'h12 : 32'h08);
            step();
        end

        // Back-pressure: 3C held while A5 pending
        value = 8'hA5;
        valid = 1'b1;
        step();
        value = 8'h3C;
        chk("bp_rdy_fall", 32'(ready), 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (ready) break;
            step();
        end
        chk("bp_rdy_back", 32'(ready), 32'd1);
        chk("bp_a5_first", 32'(segs), 32'(c_EXP_A5));
        step();
        valid = 1'b0;
        chk("bp_3c_taken", 32'(ready), 32'd0);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (ready) break;
        end
        chk("bp_3c_lat", 32'(lat), 32'd7);
        chk("bp_3c_segs", 32'(segs), 32'(c_EXP_3C));

        // Reset while A5 pending
        value = 8'hA5;
        valid = 1'b1;
        step();
        valid = 1'b0;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_segs", 32'(segs), 32'(c_EXP_RST));
        chk("mid_rst_ready", 32'(ready), 32'd0);
        hits = 0;
        for (int i = 0; i < 3 * N * DIV; i++) begin
            step();
            if (segs == c_EXP_A5) hits++;
        end
        chk("mid_rst_no_a5", 32'(hits), 32'd0);
        chk("mid_rst_hold", 32'(segs), 32'(c_EXP_RST));
        chk("mid_rst_rdy", 32'(ready), 32'd1);

        // Leading-zero patterns
        write_commit(8'h07, lat);
        chk("v07_segs", 32'(segs), 32'(c_EXP_07));
        chk("v07_scan", 32'(scan_seg), 32'h78);
        write_commit(8'h00, lat);
        chk("v00_segs", 32'(segs), 32'(c_EXP_00));
        chk("v00_lat_le9", 32'(lat <= 9), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
